// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester and transmitter signals around uart_tx_arbiter.
//   req_valid[3:0]  : per-requester byte-pending flags
//   req_data[31:0]  : requester i byte on bits [8i+7:8i]
//   req_ack[3:0]    : one-cycle capture pulse back to the granted requester
//   tx_byte[7:0]    : byte presented to the 8N1 transmitter
//   tx_send         : one-cycle start pulse to the transmitter
//   tx_done         : one-cycle completion pulse from the transmitter
//   busy            : arbiter is not idle
//   grant_id[1:0]   : current / most recent granted requester
//   timeout_err     : sticky abandoned-transfer flag
// The master modport is the environment side (requesters plus transmitter);
// the slave modport is the arbiter itself.
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    modport master (
        output req_valid, req_data, tx_done,
        input  req_ack, tx_byte, tx_send, busy, grant_id, timeout_err
    );

    modport slave (
        input  req_valid, req_data, tx_done,
        output req_ack, tx_byte, tx_send, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among 4 requesters,
// one byte per grant. Three-state FSM: IDLE -> SEND -> WAIT -> IDLE.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : uart_tx_arbiter_if.slave (requester handshake + transmitter link)
// Parameter:
//   TIMEOUT : WAIT cycles without tx_done before the byte is abandoned (1..65535)
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic [1:0]  last_grant;
    logic [1:0]  pick_idx;

    logic [3:0]  req_ack_r;
    logic [7:0]  tx_byte_r;
    logic        tx_send_r;
    logic        busy_r;
    logic [1:0]  grant_id_r;
    logic        timeout_err_r;

    // First set bit searching upward from last+1 with wrap. The loop walks
    // the offsets from farthest to nearest so the nearest hit overwrites.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + k[1:0];
            if (valid[cand]) begin
                idx = cand;
            end
        end
        return idx;
    endfunction

    assign pick_idx = rr_pick(bus.req_valid, last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= 16'd0;
            last_grant    <= 2'd3;
            req_ack_r     <= 4'b0000;
            tx_byte_r     <= 8'd0;
            tx_send_r     <= 1'b0;
            busy_r        <= 1'b0;
            grant_id_r    <= 2'd0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        state      <= SEND;
                        busy_r     <= 1'b1;
                        tx_send_r  <= 1'b1;
                        req_ack_r  <= 4'b0001 << pick_idx;
                        tx_byte_r  <= bus.req_data[{pick_idx, 3'b000} +: 8];
                        grant_id_r <= pick_idx;
                    end
                end

                SEND: begin
                    // Ack and start pulse live for this single cycle only.
                    state     <= WAIT;
                    tx_send_r <= 1'b0;
                    req_ack_r <= 4'b0000;
                    wait_cnt  <= 16'd0;
                end

                WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // wait_cnt counts completed WAIT cycles, so the cycle with
                    // wait_cnt == TIMEOUT-1 is the TIMEOUT-th and final one.
                    // Completion is tested first so it wins a tie.
                    if (bus.tx_done) begin
                        state      <= IDLE;
                        busy_r     <= 1'b0;
                        last_grant <= grant_id_r;
                    end else if (wait_cnt == TIMEOUT - 16'd1) begin
                        state         <= IDLE;
                        busy_r        <= 1'b0;
                        last_grant    <= grant_id_r;
                        timeout_err_r <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy_r    <= 1'b0;
                    tx_send_r <= 1'b0;
                    req_ack_r <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.req_ack     = req_ack_r;
    assign bus.tx_byte     = tx_byte_r;
    assign bus.tx_send     = tx_send_r;
    assign bus.busy        = busy_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with TIMEOUT=8.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT(16'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advance until tx_send is seen, bounded to 10 cycles.
    task automatic wait_send(input string tag);
        int n;
        n = 0;
        while (bus.tx_send !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (bus.tx_send !== 1'b1) check_eq({tag, "_send_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'd0;
        bus.tx_done   = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_busy",    32'(bus.busy),        32'd0);
        check_eq("rst_send",    32'(bus.tx_send),     32'd0);
        check_eq("rst_ack",     32'(bus.req_ack),     32'd0);
        check_eq("rst_byte",    32'(bus.tx_byte),     32'd0);
        check_eq("rst_gid",     32'(bus.grant_id),    32'd0);
        check_eq("rst_terr",    32'(bus.timeout_err), 32'd0);

        // Single request from requester 2
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00A5_0000;
        tick();
        check_eq("single_send", 32'(bus.tx_send),  32'd1);
        check_eq("single_ack",  32'(bus.req_ack),  32'b0100);
        check_eq("single_byte", 32'(bus.tx_byte),  32'hA5);
        check_eq("single_gid",  32'(bus.grant_id), 32'd2);
        check_eq("single_busy", 32'(bus.busy),     32'd1);
        bus.req_valid = 4'b0000;
        tick();
        check_eq("single_send_low", 32'(bus.tx_send), 32'd0);
        check_eq("single_ack_low",  32'(bus.req_ack), 32'd0);
        check_eq("single_wait_busy", 32'(bus.busy),   32'd1);
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_eq("single_idle",     32'(bus.busy),     32'd0);
        check_eq("single_hold_gid", 32'(bus.grant_id), 32'd2);
        check_eq("single_hold_byte", 32'(bus.tx_byte), 32'hA5);

        // Spurious tx_done in IDLE
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_eq("spur_idle_busy", 32'(bus.busy),        32'd0);
        check_eq("spur_idle_ack",  32'(bus.req_ack),     32'd0);
        check_eq("spur_idle_terr", 32'(bus.timeout_err), 32'd0);

        // Spurious tx_done in SEND; last grant was 2 so requester 0 wins via wrap
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_005B;
        wait_send("spur_send");
        check_eq("spur_send_gid",  32'(bus.grant_id), 32'd0);
        check_eq("spur_send_byte", 32'(bus.tx_byte),  32'h5B);
        bus.req_valid = 4'b0000;
        bus.tx_done   = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_eq("spur_send_busy", 32'(bus.busy),    32'd1);
        check_eq("spur_send_ack",  32'(bus.req_ack), 32'd0);
        tick();
        check_eq("spur_send_busy2", 32'(bus.busy), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_eq("spur_send_done", 32'(bus.busy),        32'd0);
        check_eq("spur_send_terr", 32'(bus.timeout_err), 32'd0);

        // Round robin with all requesters held high
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h4433_2211;
        for (int g = 0; g < 5; g++) begin
            logic [1:0] e;
            e = 2'(g % 4);
            wait_send("rr");
            check_eq("rr_gid",  32'(bus.grant_id), 32'(e));
            check_eq("rr_ack",  32'(bus.req_ack),  32'(4'b0001 << e));
            check_eq("rr_byte", 32'(bus.tx_byte),  32'h11 * (32'(e) + 32'd1));
            tick();
            check_eq("rr_ack_once", 32'(bus.req_ack), 32'd0);
            repeat (4) tick();
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            check_eq("rr_idle", 32'(bus.busy), 32'd0);
        end
        bus.req_valid = 4'b0000;

        // Timeout: requester 1 never completes, requester 2 is waiting
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h003C_5A00;
        wait_send("to");
        check_eq("to_gid", 32'(bus.grant_id), 32'd1);
        bus.req_valid = 4'b0100;
        repeat (8) tick();
        check_eq("to_wait8_busy", 32'(bus.busy),        32'd1);
        check_eq("to_wait8_terr", 32'(bus.timeout_err), 32'd0);
        tick();
        check_eq("to_idle",  32'(bus.busy),        32'd0);
        check_eq("to_flag",  32'(bus.timeout_err), 32'd1);
        tick();
        check_eq("to_next_send", 32'(bus.tx_send),  32'd1);
        check_eq("to_next_gid",  32'(bus.grant_id), 32'd2);
        check_eq("to_next_byte", 32'(bus.tx_byte),  32'h3C);
        bus.req_valid = 4'b0000;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_eq("to_sticky", 32'(bus.timeout_err), 32'd1);

        // Tie: completion on the terminal timeout cycle
        do_reset();
        check_eq("tie_rst_terr", 32'(bus.timeout_err), 32'd0);
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0042;
        wait_send("tie");
        bus.req_valid = 4'b0000;
        repeat (8) tick();
        check_eq("tie_busy", 32'(bus.busy), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check_eq("tie_idle", 32'(bus.busy),        32'd0);
        check_eq("tie_terr", 32'(bus.timeout_err), 32'd0);

        // Reset in the middle of WAIT with requests still pending
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_data  = 32'h7700_0011;
        wait_send("mid");
        check_eq("mid_gid", 32'(bus.grant_id), 32'd3);
        bus.req_valid = 4'b1001;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_busy", 32'(bus.busy),     32'd0);
        check_eq("mid_rst_send", 32'(bus.tx_send),  32'd0);
        check_eq("mid_rst_ack",  32'(bus.req_ack),  32'd0);
        check_eq("mid_rst_gid",  32'(bus.grant_id), 32'd0);
        check_eq("mid_rst_byte", 32'(bus.tx_byte),  32'd0);
        rst = 1'b0;
        tick();
        check_eq("mid_regrant_send", 32'(bus.tx_send),  32'd1);
        check_eq("mid_regrant_gid",  32'(bus.grant_id), 32'd0);
        check_eq("mid_regrant_ack",  32'(bus.req_ack),  32'b0001);
        check_eq("mid_regrant_byte", 32'(bus.tx_byte),  32'h11);
        bus.req_valid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
